// File: rtl/load_store_unit.sv
// Purpose : RV32I memory stage; drives a single-outstanding req/ack data bus for LOAD/STORE, passes ALU results through otherwise.
// Latency : non-memory op -> out_valid 1 cycle after accept; memory op -> mem_req 1 cycle after accept, out_valid the edge after mem_ack.
// Backpress: one instruction in flight; in_ready only in IDLE, result held until out_valid && out_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             upstream handshake; in_opcode, in_funct3, in_alu_result, in_rs2, in_rd, in_rd_we payload
//   mem_req/mem_we/mem_addr       data bus request (word-aligned), held until mem_ack or timeout
//   mem_wdata/mem_wstrb           lane-replicated store data and byte strobes (strobes 0 for loads)
//   mem_ack/mem_rdata             bus completion, read data valid in the same cycle
//   out_valid/out_ready           writeback handshake; out_we, out_rd, out_data, out_err, out_cause payload
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_we,
    output logic [4:0]  out_rd,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic [3:0]  out_cause
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value at which the last permitted wait cycle is in progress.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_is_store;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic          r_mem_req, r_mem_we;
    logic [31:0]   r_mem_addr, r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_out_valid, r_out_we, r_out_err;
    logic [4:0]    r_out_rd;
    logic [31:0]   r_out_data;
    logic [3:0]    r_out_cause;

    logic        w_accept, w_is_load, w_is_store, w_illegal, w_misalign, w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_shifted, w_load_data;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_is_load  = (in_opcode == 7'b0000011);
    assign w_is_store = (in_opcode == 7'b0100011);
    assign w_illegal  = (w_is_load  && (in_funct3 == 3'd3 || in_funct3 == 3'd6 || in_funct3 == 3'd7)) ||
                        (w_is_store && (in_funct3 >= 3'd3));
    // funct3[1:0] encodes access size for both loads and stores (0 byte, 1 half, 2 word).
    assign w_misalign = ((in_funct3[1:0] == 2'd1) && in_alu_result[0]) ||
                        ((in_funct3[1:0] == 2'd2) && (in_alu_result[1:0] != 2'd0));
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_wstrb = 4'hF;
        w_wdata = in_rs2;
        case (in_funct3[1:0])
            2'd0: begin
                w_wstrb = 4'b0001 << in_alu_result[1:0];
                w_wdata = {4{in_rs2[7:0]}};
            end
            2'd1: begin
                w_wstrb = 4'b0011 << in_alu_result[1:0];
                w_wdata = {2{in_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_f3)
            3'd0: w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'd1: w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4: w_load_data = {24'd0, w_shifted[7:0]};
            3'd5: w_load_data = {16'd0, w_shifted[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_store  <= 1'b0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_we    <= 1'b0;
            r_out_rd    <= 5'd0;
            r_out_data  <= 32'd0;
            r_out_err   <= 1'b0;
            r_out_cause <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_out_rd   <= in_rd;
                        r_f3       <= in_funct3;
                        r_off      <= in_alu_result[1:0];
                        r_is_store <= w_is_store;
                        r_out_err   <= 1'b0;
                        r_out_cause <= 4'd0;
                        r_out_we    <= 1'b0;
                        r_out_data  <= 32'd0;
                        if (!w_is_load && !w_is_store) begin
                            r_out_data  <= in_alu_result;
                            r_out_we    <= in_rd_we && (in_rd != 5'd0);
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (w_illegal) begin
                            r_out_err   <= 1'b1;
                            r_out_cause <= 4'd2;
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (w_misalign) begin
                            r_out_err   <= 1'b1;
                            r_out_cause <= w_is_store ? 4'd6 : 4'd4;
                            r_out_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_store;
                            r_mem_addr  <= {in_alu_result[31:2], 2'b00};
                            r_mem_wstrb <= w_is_store ? w_wstrb : 4'd0;
                            r_mem_wdata <= w_is_store ? w_wdata : 32'd0;
                            r_cnt       <= '0;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (mem_ack || w_timeout) begin
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wstrb <= 4'd0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESP;
                        if (mem_ack && !r_is_store) begin
                            r_out_data <= w_load_data;
                            r_out_we   <= (r_out_rd != 5'd0);
                        end
                        if (!mem_ack) begin
                            r_out_err   <= 1'b1;
                            r_out_cause <= r_is_store ? 4'd7 : 4'd5;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign out_valid = r_out_valid;
    assign out_we    = r_out_we;
    assign out_rd    = r_out_rd;
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign out_cause = r_out_cause;

endmodule
